// File: rtl/parity_pkg.sv
// Shared types and sizes for the serial parity checker.
package parity_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating count of errored frames; clear has priority over increment.
module parity_err_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_serial_checker.sv
// Receives start/8 data/parity/stop frames one bit per Bit_En strobe and
// reports the byte with parity and framing status.
module parity_serial_checker
    import parity_pkg::*;
#(
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned ERR_CNT_W  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Bit_En,
    input  logic                 Rx_In,
    input  logic                 Err_Clr,
    output logic [7:0]           Data_Out,
    output logic                 Data_Valid,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Busy,
    output logic [ERR_CNT_W-1:0] Err_Count
);

    state_e                 state_q,    state_d;
    logic [IDX_W-1:0]       idx_q,      idx_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   run_par_q,  run_par_d;
    logic                   par_bit_q,  par_bit_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   valid_q,    valid_d;
    logic                   perr_q,     perr_d;
    logic                   ferr_q,     ferr_d;
    logic                   busy_q,     busy_d;
    logic                   inc_c;

    // Next-state and output decode; nothing moves without a Bit_En strobe.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        run_par_d  = run_par_q;
        par_bit_d  = par_bit_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        inc_c      = 1'b0;

        if (Bit_En) begin
            case (state_q)
                ST_IDLE: begin
                    if (!Rx_In) begin
                        state_d   = ST_DATA;
                        idx_d     = '0;
                        run_par_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d[idx_q] = Rx_In;
                    run_par_d      = run_par_q ^ Rx_In;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_bit_d = Rx_In;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    state_d    = ST_IDLE;
                    idx_d      = '0;
                    data_out_d = shift_q;
                    perr_d     = run_par_q ^ par_bit_q ^ PARITY_ODD;
                    ferr_d     = ~Rx_In;
                    valid_d    = 1'b1;
                    inc_c      = perr_d | ferr_d;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            run_par_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            run_par_q  <= run_par_d;
            par_bit_q  <= par_bit_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    parity_err_counter #(
        .W (ERR_CNT_W)
    ) u_err_counter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .inc_i   (inc_c),
        .clr_i   (Err_Clr),
        .count_o (Err_Count)
    );

    assign Data_Out   = data_out_q;
    assign Data_Valid = valid_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_parity_serial_checker.sv
// Drives even- and odd-parity checkers with the same serial stream and
// scores every completed frame against a queue of expected results.
module tb_parity_serial_checker;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Bit_En;
    logic       Rx_In;
    logic       Err_Clr;

    logic [7:0] do_e, do_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
    logic [3:0] cnt_e, cnt_o;

    always #5 Clk = ~Clk;

    parity_serial_checker #(.PARITY_ODD(1'b0), .ERR_CNT_W(4)) u_even (
        .Clk(Clk), .Reset_n(Reset_n), .Bit_En(Bit_En), .Rx_In(Rx_In), .Err_Clr(Err_Clr),
        .Data_Out(do_e), .Data_Valid(dv_e), .Parity_Err(pe_e), .Frame_Err(fe_e),
        .Busy(busy_e), .Err_Count(cnt_e)
    );

    parity_serial_checker #(.PARITY_ODD(1'b1), .ERR_CNT_W(4)) u_odd (
        .Clk(Clk), .Reset_n(Reset_n), .Bit_En(Bit_En), .Rx_In(Rx_In), .Err_Clr(Err_Clr),
        .Data_Out(do_o), .Data_Valid(dv_o), .Parity_Err(pe_o), .Frame_Err(fe_o),
        .Busy(busy_o), .Err_Count(cnt_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe_even;
        logic       pe_odd;
        logic       fe;
        logic       clr;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] mcnt_e = 4'd0;
    logic [3:0] mcnt_o = 4'd0;
    logic [7:0] last_data = 8'h00;
    logic       prev_dv = 1'b0;
    logic [7:0] rd;
    logic       rp, rs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected error count after a frame completes, given clear and error.
    function automatic logic [3:0] next_cnt(input logic [3:0] c, input logic err, input logic clr);
        if (clr) return 4'd0;
        if (err && c != 4'hF) return c + 4'd1;
        return c;
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && (dv_e || dv_o)) begin
            check_eq("dv_agree", 32'(dv_o), 32'(dv_e));
            check_eq("dv_single_cycle", 32'(prev_dv), 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 32'(dv_e), 32'd0);
            end else begin
                mon_e     = sb.pop_front();
                mcnt_e    = next_cnt(mcnt_e, mon_e.pe_even | mon_e.fe, mon_e.clr);
                mcnt_o    = next_cnt(mcnt_o, mon_e.pe_odd  | mon_e.fe, mon_e.clr);
                last_data = mon_e.data;
                check_eq("data_even", 32'(do_e), 32'(mon_e.data));
                check_eq("data_odd",  32'(do_o), 32'(mon_e.data));
                check_eq("perr_even", 32'(pe_e), 32'(mon_e.pe_even));
                check_eq("perr_odd",  32'(pe_o), 32'(mon_e.pe_odd));
                check_eq("ferr_even", 32'(fe_e), 32'(mon_e.fe));
                check_eq("ferr_odd",  32'(fe_o), 32'(mon_e.fe));
                check_eq("cnt_even",  32'(cnt_e), 32'(mcnt_e));
                check_eq("cnt_odd",   32'(cnt_o), 32'(mcnt_o));
            end
        end
        prev_dv = dv_e;
    end

    task automatic send_bit(input logic b, input logic clr);
        @(posedge Clk);
        #1;
        Rx_In   = b;
        Bit_En  = 1'b1;
        Err_Clr = clr;
    endtask

    task automatic idle(input int n);
        @(posedge Clk);
        #1;
        Bit_En  = 1'b0;
        Err_Clr = 1'b0;
        Rx_In   = 1'b1;
        repeat (n - 1) @(posedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic clr);
        exp_t e;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        e.data    = d;
        e.pe_even = (^d) ^ p;
        e.pe_odd  = (^d) ^ p ^ 1'b1;
        e.fe      = ~s;
        e.clr     = clr;
        sb.push_back(e);
        send_bit(s, clr);
    endtask

    initial begin
        Reset_n = 1'b0;
        Bit_En  = 1'b0;
        Rx_In   = 1'b1;
        Err_Clr = 1'b0;
        #1;
        check_eq("rst_data",  32'(do_e),   32'h00);
        check_eq("rst_valid", 32'(dv_e),   32'd0);
        check_eq("rst_perr",  32'(pe_e),   32'd0);
        check_eq("rst_ferr",  32'(fe_e),   32'd0);
        check_eq("rst_busy",  32'(busy_e), 32'd0);
        check_eq("rst_cnt",   32'(cnt_e),  32'd0);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Clean frame, then parity error, then framing error with a back-to-back frame.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        idle(4);
        @(negedge Clk);
        check_eq("hold_data", 32'(do_e),   32'h81);
        check_eq("idle_busy", 32'(busy_e), 32'd0);
        check_eq("cnt_after_errs", 32'(cnt_e), 32'd2);

        // Standalone clear.
        @(posedge Clk);
        #1 Err_Clr = 1'b1;
        @(posedge Clk);
        #1 Err_Clr = 1'b0;
        mcnt_e = 4'd0;
        mcnt_o = 4'd0;
        @(negedge Clk);
        check_eq("clr_even", 32'(cnt_e), 32'd0);
        check_eq("clr_odd",  32'(cnt_o), 32'd0);

        // Saturation, then clear coinciding with an increment.
        for (int k = 0; k < 16; k++) send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        idle(3);
        @(negedge Clk);
        check_eq("sat_even", 32'(cnt_e), 32'd15);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        idle(3);
        @(negedge Clk);
        check_eq("clr_wins", 32'(cnt_e), 32'd0);

        // Bit_En held low mid-DATA while the line toggles.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(rd_bit(8'hC3, i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            Bit_En = 1'b0;
            Rx_In  = ~Rx_In;
        end
        @(negedge Clk);
        check_eq("hold_busy", 32'(busy_e), 32'd1);
        check_eq("hold_out",  32'(do_e),   32'(last_data));
        for (int i = 3; i < 8; i++) send_bit(rd_bit(8'hC3, i), 1'b0);
        send_bit(1'b0, 1'b0);
        sb.push_back('{data: 8'hC3, pe_even: 1'b0, pe_odd: 1'b1, fe: 1'b0, clr: 1'b0});
        send_bit(1'b1, 1'b0);
        idle(3);

        // Errored frame so the counter is non-zero, then reset mid-frame.
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        idle(3);
        @(negedge Clk);
        check_eq("pre_rst_cnt", 32'(cnt_e), 32'd1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        Bit_En  = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy_e), 32'd0);
        check_eq("mid_rst_data", 32'(do_e),   32'h00);
        check_eq("mid_rst_cnt",  32'(cnt_e),  32'd0);
        mcnt_e    = 4'd0;
        mcnt_o    = 4'd0;
        last_data = 8'h00;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle(3);
        @(negedge Clk);
        check_eq("post_rst_data", 32'(do_e),  32'h5A);
        check_eq("post_rst_cnt",  32'(cnt_e), 32'd0);

        // Random frames, some with bad stop bits.
        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs, 1'b0);
            if (k[0]) idle(2);
        end
        idle(2);

        for (int t = 0; t < 30 && sb.size() != 0; t++) @(posedge Clk);
        @(negedge Clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
